// File: rtl/vector_draw_engine_pkg.sv
// Shared types and constants for the vector draw engine.
// Holds the default coordinate width, the command FSM state encoding
// and the signed Bresenham error width rule.
package vector_draw_engine_pkg;

  localparam int COORD_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRAW   = 2'd2
  } state_t;

  // Error term needs two extra bits: one for sign, one for dx-dy headroom.
  function automatic int err_width(input int coord_w);
    return coord_w + 2;
  endfunction

endpackage

// File: rtl/vector_draw_engine_if.sv
// Vector command interface: the sequencer (master) presents a target with a
// one-cycle draw or jump strobe; the engine (slave) answers with ready.
interface vector_draw_engine_if #(
  parameter int COORD_W = 12
);
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               draw;
  logic               jump;
  logic               ready;

  modport master (output x, output y, output draw, output jump, input ready);
  modport slave  (input x, input y, input draw, input jump, output ready);
endinterface

// File: rtl/vector_draw_engine_line_stepper.sv
// Bresenham line datapath. On setup it latches the target, the per-axis
// distances and directions, and the initial error from the current beam
// position. On each step it proposes the next point and updates the error.
// The beam position itself lives in the parent so jumps can overwrite it.
module vector_draw_engine_line_stepper
  import vector_draw_engine_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               setup,
  input  logic               step,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  input  logic [COORD_W-1:0] tgt_x,
  input  logic [COORD_W-1:0] tgt_y,
  output logic               at_end,
  output logic [COORD_W-1:0] nxt_x,
  output logic [COORD_W-1:0] nxt_y
);
  localparam int ERR_W = err_width(COORD_W);
  localparam int E2_W  = ERR_W + 1;

  logic [COORD_W-1:0]      tx_r, ty_r, dx_r, dy_r;
  logic [COORD_W-1:0]      dx_s, dy_s;
  logic                    sx_neg_r, sy_neg_r;
  logic signed [ERR_W-1:0] err_r, err_nx_s, dx_e_s, dy_e_s;
  logic signed [E2_W-1:0]  e2_s;
  logic                    move_x_s, move_y_s;

  // Absolute distances from the current beam position to the new target
  always_comb begin
    if (tgt_x >= cur_x) dx_s = tgt_x - cur_x;
    else                dx_s = cur_x - tgt_x;
    if (tgt_y >= cur_y) dy_s = tgt_y - cur_y;
    else                dy_s = cur_y - tgt_y;
  end

  // Bresenham decision: which axes advance and the resulting error term
  always_comb begin
    dx_e_s   = $signed({2'b00, dx_r});
    dy_e_s   = $signed({2'b00, dy_r});
    e2_s     = {err_r, 1'b0};
    move_x_s = (e2_s >= -$signed({3'b000, dy_r}));
    move_y_s = (e2_s <= $signed({3'b000, dx_r}));
    err_nx_s = err_r - (move_x_s ? dy_e_s : {ERR_W{1'b0}})
                     + (move_y_s ? dx_e_s : {ERR_W{1'b0}});
    nxt_x    = move_x_s ? (sx_neg_r ? cur_x - COORD_W'(1) : cur_x + COORD_W'(1)) : cur_x;
    nxt_y    = move_y_s ? (sy_neg_r ? cur_y - COORD_W'(1) : cur_y + COORD_W'(1)) : cur_y;
    at_end   = (cur_x == tx_r) && (cur_y == ty_r);
  end

  // Line parameters latched at setup; error advanced on each step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_r     <= {COORD_W{1'b0}};
      ty_r     <= {COORD_W{1'b0}};
      dx_r     <= {COORD_W{1'b0}};
      dy_r     <= {COORD_W{1'b0}};
      sx_neg_r <= 1'b0;
      sy_neg_r <= 1'b0;
      err_r    <= {ERR_W{1'b0}};
    end else if (setup) begin
      tx_r     <= tgt_x;
      ty_r     <= tgt_y;
      dx_r     <= dx_s;
      dy_r     <= dy_s;
      sx_neg_r <= (tgt_x < cur_x);
      sy_neg_r <= (tgt_y < cur_y);
      err_r    <= $signed({2'b00, dx_s}) - $signed({2'b00, dy_s});
    end else if (step) begin
      err_r    <= err_nx_s;
    end
  end

endmodule

// File: rtl/vector_draw_engine.sv
// Vector draw engine: accepts draw/jump commands and drives the X/Y DAC
// and beam blanking. Jumps move blanked and hold for a settle period;
// draws walk a Bresenham line with the beam on, one point per STEP_DIV clocks.
module vector_draw_engine
  import vector_draw_engine_pkg::*;
#(
  parameter int COORD_W     = COORD_W_DEF,
  parameter int STEP_DIV    = 1,
  parameter int JUMP_SETTLE = 64
) (
  input  logic               clk,
  input  logic               reset,
  vector_draw_engine_if.slave cmd,
  output logic [COORD_W-1:0] dac_x,
  output logic [COORD_W-1:0] dac_y,
  output logic               blank
);
  localparam int CNT_W = $clog2(JUMP_SETTLE + 1);
  localparam int DIV_W = $clog2(STEP_DIV + 1);

  state_t             state_r, state_nx;
  logic [CNT_W-1:0]   cnt_r, cnt_nx;
  logic [DIV_W-1:0]   div_r, div_nx;
  logic [COORD_W-1:0] dac_x_r, dac_y_r, dac_x_nx, dac_y_nx;
  logic               ready_r, ready_nx, blank_r, blank_nx;
  logic               setup_s, step_s, at_end_s;
  logic [COORD_W-1:0] nxt_x_s, nxt_y_s;

  vector_draw_engine_line_stepper #(.COORD_W(COORD_W)) u_stepper (
    .clk    (clk),
    .reset  (reset),
    .setup  (setup_s),
    .step   (step_s),
    .cur_x  (dac_x_r),
    .cur_y  (dac_y_r),
    .tgt_x  (cmd.x),
    .tgt_y  (cmd.y),
    .at_end (at_end_s),
    .nxt_x  (nxt_x_s),
    .nxt_y  (nxt_y_s)
  );

  // Next-state and next-output selection for the command FSM
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    div_nx   = div_r;
    dac_x_nx = dac_x_r;
    dac_y_nx = dac_y_r;
    ready_nx = ready_r;
    blank_nx = blank_r;
    setup_s  = 1'b0;
    step_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd.jump) begin
          // jump has priority over a simultaneous draw
          state_nx = ST_SETTLE;
          dac_x_nx = cmd.x;
          dac_y_nx = cmd.y;
          ready_nx = 1'b0;
          blank_nx = 1'b1;
          cnt_nx   = CNT_W'(JUMP_SETTLE - 1);
        end else if (cmd.draw) begin
          state_nx = ST_DRAW;
          setup_s  = 1'b1;
          ready_nx = 1'b0;
          blank_nx = 1'b0;
          div_nx   = {DIV_W{1'b0}};
        end else begin
          ready_nx = 1'b1;
          blank_nx = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nx = ST_IDLE;
          ready_nx = 1'b1;
        end else begin
          cnt_nx = cnt_r - CNT_W'(1);
        end
      end
      ST_DRAW: begin
        if (div_r == DIV_W'(STEP_DIV - 1)) begin
          div_nx = {DIV_W{1'b0}};
          if (at_end_s) begin
            state_nx = ST_IDLE;
            ready_nx = 1'b1;
            blank_nx = 1'b1;
          end else begin
            step_s   = 1'b1;
            dac_x_nx = nxt_x_s;
            dac_y_nx = nxt_y_s;
          end
        end else begin
          div_nx = div_r + DIV_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        ready_nx = 1'b1;
        blank_nx = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      div_r   <= {DIV_W{1'b0}};
      dac_x_r <= {COORD_W{1'b0}};
      dac_y_r <= {COORD_W{1'b0}};
      ready_r <= 1'b1;
      blank_r <= 1'b1;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      div_r   <= div_nx;
      dac_x_r <= dac_x_nx;
      dac_y_r <= dac_y_nx;
      ready_r <= ready_nx;
      blank_r <= blank_nx;
    end
  end

  assign dac_x     = dac_x_r;
  assign dac_y     = dac_y_r;
  assign blank     = blank_r;
  assign cmd.ready = ready_r;

endmodule

// File: tb/tb_vector_draw_engine.sv
// Self-checking bench for vector_draw_engine. A STEP_DIV=1 instance carries
// most scenarios; a STEP_DIV=3 instance checks the slowed draw timing.
// Expected line points come from a plain integer Bresenham reference.
module tb_vector_draw_engine;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vector_draw_engine_if #(.COORD_W(CW)) cmd1 ();
  vector_draw_engine_if #(.COORD_W(CW)) cmd3 ();
  logic [CW-1:0] dac_x1, dac_y1, dac_x3, dac_y3;
  logic          blank1, blank3;

  vector_draw_engine #(.COORD_W(CW), .STEP_DIV(1), .JUMP_SETTLE(64)) dut (
    .clk(clk), .reset(reset), .cmd(cmd1), .dac_x(dac_x1), .dac_y(dac_y1), .blank(blank1));

  vector_draw_engine #(.COORD_W(CW), .STEP_DIV(3), .JUMP_SETTLE(64)) dut3 (
    .clk(clk), .reset(reset), .cmd(cmd3), .dac_x(dac_x3), .dac_y(dac_y3), .blank(blank3));

  int tests_run = 0;
  int fails = 0;
  int mx = 0, my = 0;           // model beam position for dut
  logic [2*CW-1:0] exp_q[$];
  logic [2*CW-1:0] got_q[$];

  // Reference line: integer Bresenham from (x0,y0) to (x1,y1), endpoint inclusive
  task automatic model_line(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, cx, cy;
    exp_q.delete();
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y1 - y0 : y0 - y1;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx - dy;
    cx = x0; cy = y0;
    forever begin
      exp_q.push_back({cx[CW-1:0], cy[CW-1:0]});
      if (cx == x1 && cy == y1) break;
      e2 = 2 * err;
      if (e2 >= -dy) begin err -= dy; cx += sx; end
      if (e2 <= dx)  begin err += dx; cy += sy; end
    end
  endtask

  task automatic strobe1(input logic d, input logic j, input int tx, input int ty);
    @(negedge clk);
    cmd1.x = tx[CW-1:0]; cmd1.y = ty[CW-1:0];
    cmd1.draw = d; cmd1.jump = j;
    @(posedge clk); #1;
    cmd1.draw = 1'b0; cmd1.jump = 1'b0;
  endtask

  task automatic strobe3(input logic d, input logic j, input int tx, input int ty);
    @(negedge clk);
    cmd3.x = tx[CW-1:0]; cmd3.y = ty[CW-1:0];
    cmd3.draw = d; cmd3.jump = j;
    @(posedge clk); #1;
    cmd3.draw = 1'b0; cmd3.jump = 1'b0;
  endtask

  task automatic run_jump(input string name, input int tx, input int ty);
    int n;
    bit bl_ok;
    strobe1(1'b0, 1'b1, tx, ty);
    tests_run++;
    if ({dac_x1, dac_y1, blank1, cmd1.ready} !== {tx[CW-1:0], ty[CW-1:0], 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL %s_start: got dac=(%0d,%0d) blank=%b ready=%b, want (%0d,%0d) blank=1 ready=0",
               name, dac_x1, dac_y1, blank1, cmd1.ready, tx, ty);
    end
    n = 0; bl_ok = 1'b1;
    while (cmd1.ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
      if (blank1 !== 1'b1) bl_ok = 1'b0;
    end
    tests_run++;
    if (n !== 64) begin
      fails++;
      $display("FAIL %s_settle: ready low for %0d clks, want 64", name, n);
    end
    tests_run++;
    if (!bl_ok) begin
      fails++;
      $display("FAIL %s_blank: blank dropped during settle, want 1 throughout", name);
    end
    mx = tx; my = ty;
  endtask

  task automatic run_draw(input string name, input int tx, input int ty);
    int n, bad, dx, dy, npts;
    bit rdy_ok;
    model_line(mx, my, tx, ty);
    dx = (tx > mx) ? tx - mx : mx - tx;
    dy = (ty > my) ? ty - my : my - ty;
    npts = ((dx > dy) ? dx : dy) + 1;
    strobe1(1'b1, 1'b0, tx, ty);
    got_q.delete();
    n = 0; rdy_ok = 1'b1;
    while (blank1 === 1'b0 && n < 10000) begin
      got_q.push_back({dac_x1, dac_y1});
      if (cmd1.ready !== 1'b0) rdy_ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    tests_run++;
    if (n !== npts) begin
      fails++;
      $display("FAIL %s_beam_on: blank low %0d clks, want %0d", name, n, npts);
    end
    tests_run++;
    if (cmd1.ready !== 1'b1 || !rdy_ok) begin
      fails++;
      $display("FAIL %s_ready: ready=%b at blank rise (low-while-drawing ok=%b), want 1", name, cmd1.ready, rdy_ok);
    end
    bad = 0;
    if (got_q.size() != exp_q.size()) bad = 1;
    else
      for (int i = 0; i < got_q.size(); i++)
        if (got_q[i] !== exp_q[i]) begin
          if (bad == 0)
            $display("FAIL %s_point%0d: got (%0d,%0d), want (%0d,%0d)", name, i,
                     got_q[i][2*CW-1:CW], got_q[i][CW-1:0], exp_q[i][2*CW-1:CW], exp_q[i][CW-1:0]);
          bad++;
        end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s_points: %0d points got vs %0d want, %0d differ", name, got_q.size(), exp_q.size(), bad);
    end
    tests_run++;
    if ({dac_x1, dac_y1} !== {tx[CW-1:0], ty[CW-1:0]}) begin
      fails++;
      $display("FAIL %s_final: got (%0d,%0d), want (%0d,%0d)", name, dac_x1, dac_y1, tx, ty);
    end
    mx = tx; my = ty;
  endtask

  task automatic test_reset();
    cmd1.x = '0; cmd1.y = '0; cmd1.draw = 1'b0; cmd1.jump = 1'b0;
    cmd3.x = '0; cmd3.y = '0; cmd3.draw = 1'b0; cmd3.jump = 1'b0;
    reset = 1'b0;
    #23;
    tests_run++;
    if ({dac_x1, dac_y1, blank1, cmd1.ready} !== {{(2*CW){1'b0}}, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: dac=(%0d,%0d) blank=%b ready=%b, want (0,0) 1 1", dac_x1, dac_y1, blank1, cmd1.ready);
    end
    tests_run++;
    if ({dac_x3, dac_y3, blank3, cmd3.ready} !== {{(2*CW){1'b0}}, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL reset_state_div3: dac=(%0d,%0d) blank=%b ready=%b, want (0,0) 1 1", dac_x3, dac_y3, blank3, cmd3.ready);
    end
    @(negedge clk); reset = 1'b1;
    mx = 0; my = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_jump();
    run_jump("jump_50_0", 50, 0);
  endtask

  task automatic test_draw();
    bit mono;
    run_draw("draw_0_40", 0, 40);
    mono = 1'b1;
    for (int i = 1; i < got_q.size(); i++)
      if (got_q[i][2*CW-1:CW] > got_q[i-1][2*CW-1:CW] || got_q[i][CW-1:0] < got_q[i-1][CW-1:0])
        mono = 1'b0;
    tests_run++;
    if (!mono || got_q.size() == 0) begin
      fails++;
      $display("FAIL draw_monotonic: x not decreasing / y not increasing over %0d points", got_q.size());
    end
  endtask

  task automatic test_step_div();
    int n, chg;
    logic [CW-1:0] px, py;
    strobe3(1'b0, 1'b1, 50, 0);
    n = 0;
    while (cmd3.ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n !== 64) begin
      fails++;
      $display("FAIL div3_settle: ready low %0d clks, want 64", n);
    end
    strobe3(1'b1, 1'b0, 0, 40);
    n = 0; chg = 0; px = dac_x3; py = dac_y3;
    while (blank3 === 1'b0 && n < 10000) begin
      @(posedge clk); #1; n++;
      if (blank3 === 1'b0 && {dac_x3, dac_y3} !== {px, py}) chg++;
      px = dac_x3; py = dac_y3;
    end
    tests_run++;
    if (n !== 153) begin
      fails++;
      $display("FAIL div3_beam_on: blank low %0d clks, want 153", n);
    end
    tests_run++;
    if (chg !== 50 || {dac_x3, dac_y3} !== {12'd0, 12'd40} || cmd3.ready !== 1'b1) begin
      fails++;
      $display("FAIL div3_path: %0d moves end (%0d,%0d) ready=%b, want 50 moves end (0,40) ready=1",
               chg, dac_x3, dac_y3, cmd3.ready);
    end
  endtask

  task automatic test_zero_draw();
    run_draw("dot_0_40", 0, 40);
  endtask

  task automatic test_draw_jump_same();
    int n;
    bit bl_ok;
    strobe1(1'b1, 1'b1, 10, 10);
    tests_run++;
    if ({dac_x1, dac_y1, blank1, cmd1.ready} !== {12'd10, 12'd10, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL both_strobes: dac=(%0d,%0d) blank=%b ready=%b, want (10,10) 1 0", dac_x1, dac_y1, blank1, cmd1.ready);
    end
    n = 0; bl_ok = 1'b1;
    while (cmd1.ready !== 1'b1 && n < 200) begin
      if (n == 3) begin cmd1.x = 12'd100; cmd1.y = 12'd100; cmd1.draw = 1'b1; end
      else cmd1.draw = 1'b0;
      @(posedge clk); #1; n++;
      if (blank1 !== 1'b1) bl_ok = 1'b0;
    end
    cmd1.draw = 1'b0;
    tests_run++;
    if (n !== 64 || !bl_ok) begin
      fails++;
      $display("FAIL both_settle: ready low %0d clks blank_ok=%b, want 64 and 1", n, bl_ok);
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if ({dac_x1, dac_y1, blank1, cmd1.ready} !== {12'd10, 12'd10, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL busy_strobe_ignored: dac=(%0d,%0d) blank=%b ready=%b, want (10,10) 1 1", dac_x1, dac_y1, blank1, cmd1.ready);
    end
    mx = 10; my = 10;
  endtask

  task automatic test_full_scale();
    run_jump("fs_jump_a", 0, 0);
    run_draw("fs_diag_up", 4095, 4095);
    run_jump("fs_jump_b", 4095, 0);
    run_draw("fs_diag_down", 0, 4095);
  endtask

  task automatic test_random();
    int op, tx, ty;
    run_jump("rnd_home", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    for (int k = 0; k < 12; k++) begin
      op = int'($urandom_range(0, 3));
      tx = int'($urandom_range(0, 255));
      ty = int'($urandom_range(0, 255));
      if (op == 0) run_jump($sformatf("rnd%0d_jump", k), tx, ty);
      else         run_draw($sformatf("rnd%0d_draw", k), tx, ty);
    end
  endtask

  task automatic test_reset_mid_draw();
    run_jump("pre_abort_jump", 0, 0);
    strobe1(1'b1, 1'b0, 4095, 4095);
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({dac_x1, dac_y1, blank1, cmd1.ready} !== {{(2*CW){1'b0}}, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL abort_reset: dac=(%0d,%0d) blank=%b ready=%b, want (0,0) 1 1", dac_x1, dac_y1, blank1, cmd1.ready);
    end
    @(negedge clk); reset = 1'b1;
    mx = 0; my = 0;
    @(posedge clk); #1;
    run_jump("post_abort_jump", 7, 9);
    run_draw("post_abort_draw", 20, 3);
  endtask

  // Watchdog so a stuck design still ends the run
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Test sequence
  initial begin
    test_reset();
    test_jump();
    test_draw();
    test_step_div();
    test_zero_draw();
    test_draw_jump_same();
    test_full_scale();
    test_random();
    test_reset_mid_draw();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
